stim_sequencer: RTL and testbench

Synthesizable stimulus program sequencer that replays a small opcode memory onto the primary inputs of a benchmark core such as b06, one vector per step, with per-word repeat counts. It owns the program counter and fetch path that sit in front of the device under test in the concolic flow. Programs are loaded through a write port, run on `start`, and end on a flagged last word. Progress is exposed for the trace/coverage logger.

---
 rtl/stim_sequencer_if.sv | 29 ++
 rtl/stim_sequencer.sv | 129 ++++++++++++
 tb/tb_stim_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_sequencer_if.sv
// rtl/stim_sequencer_if.sv - control, program-load and drive signals of stim_sequencer
interface stim_sequencer_if #(
  parameter int OP_W = 3,
  parameter int AW   = 4
);
  logic            start;
  logic            abort;
  logic            ld_we;
  logic [AW-1:0]   ld_addr;
  logic [OP_W+2:0] ld_data;
  logic [OP_W-1:0] drive;
  logic [AW-1:0]   pc;
  logic            step;
  logic            busy;
  logic            done;
  logic            ld_err;

  // sequencer side: takes commands and program words, produces the drive vector
  modport slave (
    input  start, abort, ld_we, ld_addr, ld_data,
    output drive, pc, step, busy, done, ld_err
  );

  // controller side: loads programs and starts/aborts runs
  modport master (
    output start, abort, ld_we, ld_addr, ld_data,
    input  drive, pc, step, busy, done, ld_err
  );
endinterface

// File: rtl/stim_sequencer.sv
// rtl/stim_sequencer.sv - opcode-memory stimulus sequencer with per-word repeat (option: STIM_SEQ_LOOP_EN)
module stim_sequencer #(
  parameter int OP_W       = 3,
  parameter int DEPTH      = 11,
  parameter int START_ADDR = 1,
  parameter int AW         = 4
) (
  input  logic              clock,
  input  logic              reset,
  stim_sequencer_if.slave   bus
);
  // word layout: {last, rep[1:0], drive[OP_W-1:0]}
  localparam int            WW      = OP_W + 3;
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] START_V = AW'(START_ADDR);
  localparam logic [AW-1:0] LAST_V  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [WW-1:0]   r_mem [DEPTH];
  logic [OP_W-1:0] r_drive;
  logic [AW-1:0]   r_pc;
  logic [1:0]      r_rep;
  logic            r_step;
  logic            r_busy;
  logic            r_done;
  logic            r_ld_err;

  logic [WW-1:0]   w_start_word;
  logic [WW-1:0]   w_cur_word;
  logic [WW-1:0]   w_next_word;
  logic [AW-1:0]   w_next_pc;
  logic            w_addr_ok;
  logic            w_wr_ok;
  logic            w_wr_bad;
  logic            w_end;

  // combinational fetch: memory cannot change during RUN, so reading the current word is stable
  assign w_start_word = r_mem[START_V];
  assign w_cur_word   = r_mem[r_pc];
  assign w_next_pc    = r_pc + AW'(1);
  assign w_next_word  = r_mem[w_next_pc];
  assign w_end        = w_cur_word[WW-1] || (r_pc == LAST_V);

  assign w_addr_ok = ({1'b0, bus.ld_addr} < DEPTH_V);
  assign w_wr_ok   = bus.ld_we && w_addr_ok && (r_state != S_RUN);
  assign w_wr_bad  = bus.ld_we && !w_wr_ok;

  // program write port; contents survive reset so a run can be replayed after it
  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // sequencing FSM with all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_drive  <= '0;
      r_pc     <= '0;
      r_rep    <= '0;
      r_step   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_step   <= 1'b0;
      r_ld_err <= w_wr_bad;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_drive <= '0;
        r_rep   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              r_state <= S_RUN;
              r_pc    <= START_V;
              r_drive <= w_start_word[OP_W-1:0];
              r_rep   <= w_start_word[OP_W+1:OP_W];
              r_step  <= 1'b1;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
          S_RUN: begin
            if (r_rep != 2'd0) begin
              r_rep <= r_rep - 2'd1;
            end else if (!w_end) begin
              r_pc    <= w_next_pc;
              r_drive <= w_next_word[OP_W-1:0];
              r_rep   <= w_next_word[OP_W+1:OP_W];
              r_step  <= 1'b1;
            end else begin
`ifdef STIM_SEQ_LOOP_EN
              r_pc    <= START_V;
              r_drive <= w_start_word[OP_W-1:0];
              r_rep   <= w_start_word[OP_W+1:OP_W];
              r_step  <= 1'b1;
`else
              r_state <= S_DONE;
              r_drive <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_drive <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.drive  = r_drive;
  assign bus.pc     = r_pc;
  assign bus.step   = r_step;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.ld_err = r_ld_err;
endmodule

// File: tb/tb_stim_sequencer.sv
// tb/tb_stim_sequencer.sv - self-checking bench for stim_sequencer
module tb_stim_sequencer;
  localparam int OP_W = 3, DEPTH = 11, START_ADDR = 1, AW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  stim_sequencer_if #(.OP_W(OP_W), .AW(AW)) bus ();

  stim_sequencer #(.OP_W(OP_W), .DEPTH(DEPTH), .START_ADDR(START_ADDR), .AW(AW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int pc;
    int drv;
    int stp;
  } ent_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;

  logic [5:0] m_mem [DEPTH];
  ent_t       m_q[$];
  mode_t      m_mode = M_IDLE;
  int exp_drive = 0, exp_pc = 0, exp_step = 0, exp_busy = 0, exp_done = 0, exp_ld_err = 0;
  bit exp_pc_valid = 1'b1;

  // expand the program into one entry per cycle it will occupy
  function automatic void build();
    int a = START_ADDR;
    m_q.delete();
    for (int n = 0; n < DEPTH; n++) begin
      for (int j = 0; j <= int'(m_mem[a][4:3]); j++) begin
        m_q.push_back('{pc: a, drv: int'(m_mem[a][2:0]), stp: (j == 0) ? 1 : 0});
      end
      if (m_mem[a][5] || a == DEPTH - 1) break;
      a++;
    end
  endfunction

  function automatic void take();
    ent_t e = m_q.pop_front();
    m_mode = M_RUN;
    exp_busy = 1; exp_done = 0;
    exp_drive = e.drv; exp_pc = e.pc; exp_step = e.stp;
    exp_pc_valid = 1'b1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_q.delete();
      exp_drive = 0; exp_pc = 0; exp_step = 0; exp_busy = 0; exp_done = 0; exp_ld_err = 0;
      exp_pc_valid = 1'b1;
    end else begin
      bit err, acc;
      err = bus.ld_we && (m_mode == M_RUN || int'(bus.ld_addr) >= DEPTH);
      acc = bus.ld_we && !err;
      exp_step = 0;
      if (bus.abort) begin
        m_mode = M_IDLE; m_q.delete();
        exp_drive = 0; exp_busy = 0; exp_done = 0; exp_pc_valid = 1'b0;
      end else if (m_mode != M_RUN && bus.start) begin
        build(); take();
      end else if (m_mode == M_RUN) begin
        if (m_q.size() > 0) take();
        else begin
`ifdef STIM_SEQ_LOOP_EN
          build(); take();
`else
          m_mode = M_DONE; exp_drive = 0; exp_busy = 0; exp_done = 1;
`endif
        end
      end
      exp_ld_err = err ? 1 : 0;
      if (acc) m_mem[bus.ld_addr] = bus.ld_data;
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("drive", int'(bus.drive), exp_drive);
      chk("step", int'(bus.step), exp_step);
      chk("busy", int'(bus.busy), exp_busy);
      chk("done", int'(bus.done), exp_done);
      chk("ld_err", int'(bus.ld_err), exp_ld_err);
      if (exp_pc_valid) chk("pc", int'(bus.pc), exp_pc);
    end
  end

  // ---------------- stimulus (tasks entered at a negedge) ----------------
  task automatic write_word(input int addr, input logic [5:0] data);
    bus.ld_we = 1'b1; bus.ld_addr = AW'(addr); bus.ld_data = data;
    @(negedge clock);
    bus.ld_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(name, int'(bus.done), 1);
  endtask

  task automatic load_prog1();
    write_word(1, 6'b0_00_101);
    write_word(2, 6'b0_10_010);
    write_word(3, 6'b1_00_111);
  endtask

  // literal expectations for the three-word program: 101,010,010,010,111 then DONE
  task automatic check_prog1(input string name);
    int seq [5] = '{5, 2, 2, 2, 7};
    int steps = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk({name, "_drive"}, int'(bus.drive), seq[i]);
      steps += int'(bus.step);
      @(negedge clock);
    end
    chk({name, "_steps"}, steps, 3);
    chk({name, "_done"}, int'(bus.done), 1);
    chk({name, "_done_drive"}, int'(bus.drive), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.ld_we = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_drive", int'(bus.drive), 0);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    @(negedge clock);
    load_prog1();
`ifdef STIM_SEQ_LOOP_EN
    begin
      int seq [5] = '{5, 2, 2, 2, 7};
      pulse_start();
      for (int i = 0; i < 12; i++) begin
        chk("loop_drive", int'(bus.drive), seq[i % 5]);
        chk("loop_done", int'(bus.done), 0);
        @(negedge clock);
      end
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      chk("loop_abort_busy", int'(bus.busy), 0);
    end
`else
    check_prog1("prog1");
    check_prog1("prog1_rerun");

    // no last bit anywhere: the run must stop at the top address
    begin
      int last_pc = -1;
      int n = 0;
      for (int a = 1; a < DEPTH; a++) begin
        logic [5:0] w;
        w = {1'b0, (a == 5) ? 2'd1 : 2'd0, 3'(a)};
        write_word(a, w);
      end
      pulse_start();
      while (bus.busy && n < 40) begin
        last_pc = int'(bus.pc);
        @(negedge clock);
        n++;
      end
      chk("nolast_last_pc", last_pc, 10);
      chk("nolast_done", int'(bus.done), 1);
    end

    // abort in the second cycle of a rep=3 word, then restart
    write_word(1, 6'b0_11_110);
    write_word(2, 6'b1_00_001);
    pulse_start();
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_drive", int'(bus.drive), 0);
    chk("abort_done", int'(bus.done), 0);
    pulse_start();
    chk("restart_pc", int'(bus.pc), 1);
    chk("restart_drive", int'(bus.drive), 6);

    // rejected writes: one during RUN, one out of range while stopped
    write_word(2, 6'b1_00_011);
    chk("ld_err_run", int'(bus.ld_err), 1);
    wait_done("run_done");
    write_word(12, 6'b1_00_100);
    chk("ld_err_range", int'(bus.ld_err), 1);
    pulse_start();
    repeat (4) @(negedge clock);
    chk("readback_w2", int'(bus.drive), 1);
    wait_done("readback_done");

    // asynchronous reset mid-run, then replay
    load_prog1();
    pulse_start();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset_drive", int'(bus.drive), 0);
    chk("areset_busy", int'(bus.busy), 0);
    chk("areset_step", int'(bus.step), 0);
    chk("areset_pc", int'(bus.pc), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("areset_stays_idle", int'(bus.busy), 0);
    check_prog1("after_reset");
`endif
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
